accumulator_sequencer: RTL and testbench
========================================

Name: accumulator_sequencer

Overview:
- Fetch/decode/execute micro-sequencer for the 8-bit accumulator CPU.
- Drives every control strobe on the shared data bus: PC, MAR, RAM, IR, accumulator, B register, ALU and output register.
- The accumulator is driven through load_a, load_immediate_a and a_out (its output enable).
- Guarantees exactly one bus driver per step and never starts a new instruction until the current one has retired.

Parameters:
- OPW, 4, opcode width; the IR upper field. The operand is the lower field.
- NSTEP, 5, maximum micro-steps per instruction (T0..T4).

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; forces state to T0, not halted
- run  in  1  1 = sequencer may begin a fetch at T0; 0 = hold at T0
- ir_opcode  in  OPW  opcode field of the instruction register
- pc_out  out  1  PC drives bus
- pc_inc  out  1  PC increments
- pc_load  out  1  PC loads from bus
- mar_load  out  1  MAR loads from bus
- ram_out  out  1  RAM drives bus
- ram_load  out  1  RAM writes bus at MAR
- ir_load  out  1  IR loads from bus
- ir_out  out  1  IR operand field drives bus (upper bits zero)
- load_a  out  1  accumulator loads full word
- load_immediate_a  out  1  accumulator loads lower nibble and clears upper nibble
- a_out  out  1  accumulator output enable onto bus
- b_load  out  1  B register loads from bus
- alu_out  out  1  ALU result drives bus
- alu_sub  out  1  ALU op select: 0 = add, 1 = subtract
- out_load  out  1  output register loads from bus
- halted  out  1  1 while in HALT state
- step  out  3  current micro-step index (debug)

Behaviour:
- State: 3-bit step counter T0..T4, plus a HALT flag. Outputs are combinational from (step, ir_opcode, halted, run), gated off by reset.
- Reset: while reset=1, every strobe output is 0. On the next edge, step=0 and halted=0.
- Fetch:
  - T0, only if run=1: pc_out, mar_load.
  - T1: ram_out, ir_load, pc_inc.
  - If run=0 at T0: no strobes, step stays 0. Once T1 is entered, the instruction completes regardless of run.
- Opcode constants: NOP=0, LDA=1, LDI=2, ADD=3, SUB=4, STA=5, JMP=6, OUT=7, HLT=F. Any other opcode executes as NOP.
- Execute, from T2, decoded from ir_opcode (valid from T2 onward):
  - LDA: T2 ir_out, mar_load; T3 ram_out, load_a.
  - LDI: T2 ir_out, load_immediate_a.
  - ADD: T2 ir_out, mar_load; T3 ram_out, b_load; T4 alu_out, load_a, alu_sub=0.
  - SUB: same as ADD with alu_sub=1 in T4.
  - STA: T2 ir_out, mar_load; T3 a_out, ram_load.
  - JMP: T2 ir_out, pc_load.
  - OUT: T2 a_out, out_load.
  - NOP: T2 no strobes.
  - HLT: T2 no strobes; halted=1 on the next edge.
- Retire: after an instruction's last step, step returns to 0 on the next edge. There are no idle steps, so instruction lengths are NOP/LDI/JMP/OUT/HLT 3, LDA/STA 4, ADD/SUB 5 cycles.
- HALT: all strobes 0, step holds at 0. halted stays 1 until reset; run is ignored.
- Invariants, checked by assertion:
  - At most one of {pc_out, ram_out, ir_out, a_out, alu_out} is 1 in any cycle.
  - load_a and load_immediate_a are never both 1.
  - step never exceeds 4.
- Reset mid-instruction (any step): all strobes drop in the same cycle. The next cycle is T0, and the partially executed instruction is abandoned.

Decomposition:
- Shared package:
  - opcode constants;
  - step constants T0..T4;
  - a control-word struct/bit-index constants for the 15 strobes.
- Sub-module control_decoder: purely combinational, maps (step, ir_opcode) to control word and last_step flag.
- The sequencer keeps only the counter, the HALT flag, and the run/reset gating.

Test Plan:
- Reset for 2 cycles with run=1 and ir_opcode=3 -> all strobes 0 during reset; next cycle step=0 with pc_out=1 and mar_load=1.
- run=0 for 4 cycles after reset -> step stays 0 and all strobes 0; raise run -> T0 fetch strobes appear the same cycle.
- LDI (opcode 2) -> T2 shows ir_out=1 and load_immediate_a=1 with load_a=0; step returns to 0 after 3 cycles total.
- ADD then SUB back-to-back -> 5-cycle sequences each; T4 alu_sub=0 then 1; one-hot bus-driver check holds every cycle.
- HLT (opcode F) -> halted=1 from cycle 4 on; toggling run has no effect; reset clears halted and fetch resumes.
- Assert reset during T3 of STA -> ram_load and a_out drop immediately; next cycle is T0; undefined opcode 9 completes in 3 cycles with no execute strobes.

Source files
------------

// File: rtl/accumulator_sequencer_pkg.sv
// Shared constants for the accumulator CPU sequencer: opcodes, micro-step indices
// and the 15-strobe control word layout.
package accumulator_sequencer_pkg;

  localparam int OP_W   = 4;
  localparam int STEP_W = 3;
  localparam int CW_W   = 15;

  localparam logic [OP_W-1:0] OP_NOP = 4'h0;
  localparam logic [OP_W-1:0] OP_LDA = 4'h1;
  localparam logic [OP_W-1:0] OP_LDI = 4'h2;
  localparam logic [OP_W-1:0] OP_ADD = 4'h3;
  localparam logic [OP_W-1:0] OP_SUB = 4'h4;
  localparam logic [OP_W-1:0] OP_STA = 4'h5;
  localparam logic [OP_W-1:0] OP_JMP = 4'h6;
  localparam logic [OP_W-1:0] OP_OUT = 4'h7;
  localparam logic [OP_W-1:0] OP_HLT = 4'hF;

  localparam logic [STEP_W-1:0] T0 = 3'd0;
  localparam logic [STEP_W-1:0] T1 = 3'd1;
  localparam logic [STEP_W-1:0] T2 = 3'd2;
  localparam logic [STEP_W-1:0] T3 = 3'd3;
  localparam logic [STEP_W-1:0] T4 = 3'd4;

  // Field order fixes the bit index of each strobe: pc_out is bit 0, out_load bit 14.
  typedef struct packed {
    logic out_load;
    logic alu_sub;
    logic alu_out;
    logic b_load;
    logic a_out;
    logic load_immediate_a;
    logic load_a;
    logic ir_out;
    logic ir_load;
    logic ram_load;
    logic ram_out;
    logic mar_load;
    logic pc_load;
    logic pc_inc;
    logic pc_out;
  } ctrl_t;

endpackage

// File: rtl/accumulator_sequencer_control_decoder.sv
// Combinational map from (step, opcode) to control word, last-step and halt flags.
// Zero latency; no flow control.
module control_decoder
  import accumulator_sequencer_pkg::*;
#(
  parameter int OPW = 4
) (
  input  logic [STEP_W-1:0] step,
  input  logic [OPW-1:0]    ir_opcode,
  output logic [CW_W-1:0]   ctrl,
  output logic              last_step,
  output logic              is_halt
);

  ctrl_t c;

  assign ctrl = c;

  always_comb begin
    c         = '0;
    last_step = 1'b0;
    is_halt   = 1'b0;
    case (step)
      T0: begin
        c.pc_out   = 1'b1;
        c.mar_load = 1'b1;
      end
      T1: begin
        c.ram_out = 1'b1;
        c.ir_load = 1'b1;
        c.pc_inc  = 1'b1;
      end
      T2: begin
        case (ir_opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            c.ir_out   = 1'b1;
            c.mar_load = 1'b1;
          end
          OP_LDI: begin
            c.ir_out           = 1'b1;
            c.load_immediate_a = 1'b1;
            last_step          = 1'b1;
          end
          OP_JMP: begin
            c.ir_out  = 1'b1;
            c.pc_load = 1'b1;
            last_step = 1'b1;
          end
          OP_OUT: begin
            c.a_out    = 1'b1;
            c.out_load = 1'b1;
            last_step  = 1'b1;
          end
          OP_HLT: begin
            is_halt   = 1'b1;
            last_step = 1'b1;
          end
          default: last_step = 1'b1;
        endcase
      end
      T3: begin
        case (ir_opcode)
          OP_LDA: begin
            c.ram_out = 1'b1;
            c.load_a  = 1'b1;
            last_step = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            c.ram_out = 1'b1;
            c.b_load  = 1'b1;
          end
          OP_STA: begin
            c.a_out    = 1'b1;
            c.ram_load = 1'b1;
            last_step  = 1'b1;
          end
          default: last_step = 1'b1;
        endcase
      end
      T4: begin
        // Only ADD/SUB reach T4; anything else retires defensively.
        last_step = 1'b1;
        if (ir_opcode == OP_ADD || ir_opcode == OP_SUB) begin
          c.alu_out = 1'b1;
          c.load_a  = 1'b1;
          c.alu_sub = (ir_opcode == OP_SUB);
        end
      end
      default: last_step = 1'b1;
    endcase
  end

endmodule

// File: rtl/accumulator_sequencer.sv
// Fetch/decode/execute micro-sequencer: step counter, HALT flag, run/reset gating.
// Strobes are combinational from current step; run only gates the start of a fetch at T0.
module accumulator_sequencer
  import accumulator_sequencer_pkg::*;
#(
  parameter int OPW   = 4,
  parameter int NSTEP = 5
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           run,
  input  logic [OPW-1:0] ir_opcode,
  output logic           pc_out,
  output logic           pc_inc,
  output logic           pc_load,
  output logic           mar_load,
  output logic           ram_out,
  output logic           ram_load,
  output logic           ir_load,
  output logic           ir_out,
  output logic           load_a,
  output logic           load_immediate_a,
  output logic           a_out,
  output logic           b_load,
  output logic           alu_out,
  output logic           alu_sub,
  output logic           out_load,
  output logic           halted,
  output logic [2:0]     step
);

  localparam logic [STEP_W-1:0] LAST_T = STEP_W'(NSTEP - 1);

  logic [STEP_W-1:0] step_q;
  logic              halted_q;
  logic [CW_W-1:0]   dec_cw;
  logic              last_step;
  logic              is_halt;
  logic              idle;
  logic              gate;
  ctrl_t             cw;

  control_decoder #(.OPW(OPW)) u_decoder (
    .step      (step_q),
    .ir_opcode (ir_opcode),
    .ctrl      (dec_cw),
    .last_step (last_step),
    .is_halt   (is_halt)
  );

  assign idle = (step_q == T0) && !run;
  assign gate = reset || halted_q || idle;
  assign cw   = gate ? '0 : ctrl_t'(dec_cw);

  always_ff @(posedge clk) begin
    if (reset) begin
      step_q   <= T0;
      halted_q <= 1'b0;
    end else if (halted_q || idle) begin
      step_q <= T0;
    end else if (last_step || step_q >= LAST_T) begin
      step_q <= T0;
      if (is_halt) halted_q <= 1'b1;
    end else begin
      step_q <= step_q + 3'd1;
    end
  end

  assign pc_out           = cw.pc_out;
  assign pc_inc           = cw.pc_inc;
  assign pc_load          = cw.pc_load;
  assign mar_load         = cw.mar_load;
  assign ram_out          = cw.ram_out;
  assign ram_load         = cw.ram_load;
  assign ir_load          = cw.ir_load;
  assign ir_out           = cw.ir_out;
  assign load_a           = cw.load_a;
  assign load_immediate_a = cw.load_immediate_a;
  assign a_out            = cw.a_out;
  assign b_load           = cw.b_load;
  assign alu_out          = cw.alu_out;
  assign alu_sub          = cw.alu_sub;
  assign out_load         = cw.out_load;
  assign halted           = halted_q;
  assign step             = step_q;

  a_one_driver: assert property (@(posedge clk)
    $onehot0({pc_out, ram_out, ir_out, a_out, alu_out}));
  a_one_a_load: assert property (@(posedge clk) !(load_a && load_immediate_a));
  a_step_range: assert property (@(posedge clk) disable iff (reset) step_q <= T4);

endmodule

// File: tb/tb_accumulator_sequencer.sv
// Directed bench for accumulator_sequencer: inputs change on the falling edge,
// outputs are checked 1 ns later against hand-written control words.
module tb_accumulator_sequencer;

  localparam logic [14:0] PC_OUT   = 15'h0001;
  localparam logic [14:0] PC_INC   = 15'h0002;
  localparam logic [14:0] PC_LOAD  = 15'h0004;
  localparam logic [14:0] MAR_LOAD = 15'h0008;
  localparam logic [14:0] RAM_OUT  = 15'h0010;
  localparam logic [14:0] RAM_LOAD = 15'h0020;
  localparam logic [14:0] IR_LOAD  = 15'h0040;
  localparam logic [14:0] IR_OUT   = 15'h0080;
  localparam logic [14:0] LOAD_A   = 15'h0100;
  localparam logic [14:0] LOAD_IMM = 15'h0200;
  localparam logic [14:0] A_OUT    = 15'h0400;
  localparam logic [14:0] B_LOAD   = 15'h0800;
  localparam logic [14:0] ALU_OUT  = 15'h1000;
  localparam logic [14:0] ALU_SUB  = 15'h2000;
  localparam logic [14:0] OUT_LOAD = 15'h4000;

  localparam logic [14:0] FETCH0 = PC_OUT | MAR_LOAD;
  localparam logic [14:0] FETCH1 = RAM_OUT | IR_LOAD | PC_INC;

  logic       clk = 1'b0;
  logic       reset;
  logic       run;
  logic [3:0] ir_opcode;
  logic pc_out, pc_inc, pc_load, mar_load, ram_out, ram_load, ir_load, ir_out;
  logic load_a, load_immediate_a, a_out, b_load, alu_out, alu_sub, out_load;
  logic       halted;
  logic [2:0] step;
  logic [14:0] cw;

  int checks   = 0;
  int failures = 0;

  accumulator_sequencer #(.OPW(4), .NSTEP(5)) dut (
    .clk              (clk),
    .reset            (reset),
    .run              (run),
    .ir_opcode        (ir_opcode),
    .pc_out           (pc_out),
    .pc_inc           (pc_inc),
    .pc_load          (pc_load),
    .mar_load         (mar_load),
    .ram_out          (ram_out),
    .ram_load         (ram_load),
    .ir_load          (ir_load),
    .ir_out           (ir_out),
    .load_a           (load_a),
    .load_immediate_a (load_immediate_a),
    .a_out            (a_out),
    .b_load           (b_load),
    .alu_out          (alu_out),
    .alu_sub          (alu_sub),
    .out_load         (out_load),
    .halted           (halted),
    .step             (step)
  );

  always #5 clk = ~clk;

  assign cw = {out_load, alu_sub, alu_out, b_load, a_out, load_immediate_a, load_a,
               ir_out, ir_load, ram_load, ram_out, mar_load, pc_load, pc_inc, pc_out};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Checks the current cycle, then advances to the next falling edge.
  task automatic cyc(input string tag, input logic [2:0] exp_step,
                     input logic [14:0] exp_cw, input logic exp_halt);
    #1;
    chk({tag, ".step"}, 32'(step), 32'(exp_step));
    chk({tag, ".cw"}, 32'(cw), 32'(exp_cw));
    chk({tag, ".halted"}, 32'(halted), 32'(exp_halt));
    chk({tag, ".bus1hot"}, 32'($countones({pc_out, ram_out, ir_out, a_out, alu_out}) <= 1), 32'd1);
    @(negedge clk);
  endtask

  task automatic fetch(input string tag, input logic [3:0] op);
    ir_opcode = op;
    cyc({tag, ".t0"}, 3'd0, FETCH0, 1'b0);
    cyc({tag, ".t1"}, 3'd1, FETCH1, 1'b0);
  endtask

  initial begin
    reset     = 1'b1;
    run       = 1'b1;
    ir_opcode = 4'h3;
    @(negedge clk);
    #1;
    chk("rst1.cw", 32'(cw), 32'd0);
    @(negedge clk);
    cyc("rst2", 3'd0, 15'd0, 1'b0);

    // Release straight into ADD, then SUB back to back.
    reset = 1'b0;
    fetch("add", 4'h3);
    cyc("add.t2", 3'd2, IR_OUT | MAR_LOAD, 1'b0);
    cyc("add.t3", 3'd3, RAM_OUT | B_LOAD, 1'b0);
    cyc("add.t4", 3'd4, ALU_OUT | LOAD_A, 1'b0);
    fetch("sub", 4'h4);
    cyc("sub.t2", 3'd2, IR_OUT | MAR_LOAD, 1'b0);
    cyc("sub.t3", 3'd3, RAM_OUT | B_LOAD, 1'b0);
    cyc("sub.t4", 3'd4, ALU_OUT | LOAD_A | ALU_SUB, 1'b0);

    run = 1'b0;
    for (int i = 0; i < 4; i++) cyc("idle", 3'd0, 15'd0, 1'b0);
    run = 1'b1;

    fetch("ldi", 4'h2);
    cyc("ldi.t2", 3'd2, IR_OUT | LOAD_IMM, 1'b0);

    // Reset lands in T3 of STA: strobes drop in that cycle, T0 follows.
    fetch("sta", 4'h5);
    cyc("sta.t2", 3'd2, IR_OUT | MAR_LOAD, 1'b0);
    #1;
    chk("sta.t3.cw", 32'(cw), 32'(A_OUT | RAM_LOAD));
    reset = 1'b1;
    #1;
    chk("sta.rst.cw", 32'(cw), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    fetch("undef", 4'h9);
    cyc("undef.t2", 3'd2, 15'd0, 1'b0);
    fetch("jmp", 4'h6);
    cyc("jmp.t2", 3'd2, IR_OUT | PC_LOAD, 1'b0);
    fetch("out", 4'h7);
    cyc("out.t2", 3'd2, A_OUT | OUT_LOAD, 1'b0);
    fetch("lda", 4'h1);
    cyc("lda.t2", 3'd2, IR_OUT | MAR_LOAD, 1'b0);
    cyc("lda.t3", 3'd3, RAM_OUT | LOAD_A, 1'b0);
    fetch("nop", 4'h0);
    cyc("nop.t2", 3'd2, 15'd0, 1'b0);

    fetch("hlt", 4'hF);
    cyc("hlt.t2", 3'd2, 15'd0, 1'b0);
    ir_opcode = 4'h3;
    for (int i = 0; i < 6; i++) begin
      run = i[0];
      cyc("halt", 3'd0, 15'd0, 1'b1);
    end
    run   = 1'b1;
    reset = 1'b1;
    cyc("hrst", 3'd0, 15'd0, 1'b1);
    reset = 1'b0;
    cyc("resume.t0", 3'd0, FETCH0, 1'b0);
    cyc("resume.t1", 3'd1, FETCH1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
